// File: rtl/sbox_quarter_sequencer_pkg.sv
// Shared types and constants for the masked S-box quarter sequencer.
// Address format is {rnd lane, data byte}, indexing one BRAM_*_x49 table.
package sbox_quarter_sequencer_pkg;

    localparam int ADDR_W = 10;
    localparam int LANE_W = 8;
    localparam int RND_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_LO,
        TAG_HI
    } tag_t;

    function automatic logic [ADDR_W-1:0] sbox_addr(input logic [RND_W-1:0] rnd,
                                                    input logic [LANE_W-1:0] data);
        return {rnd, data};
    endfunction

endpackage

// File: rtl/sbox_out_fifo.sv
// Small synchronous output FIFO; head reads as zero while empty.
// A push on a full FIFO is taken only when a pop frees the slot in the same cycle.
module sbox_out_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sbox_quarter_sequencer.sv
// Issues two dual-port S-box reads per 32-bit quarter column (lanes 0/1, then 2/3)
// and reassembles the registered BRAM outputs into one word behind a credit-guarded FIFO.
module sbox_quarter_sequencer
    import sbox_quarter_sequencer_pkg::*;
#(
    parameter int BRAM_LAT   = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [7:0]        in_rnd,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [ADDR_W-1:0] bram_addrb,
    output logic              bram_en,
    output logic              bram_rst,
    input  logic [7:0]        bram_doa,
    input  logic [7:0]        bram_dob,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data
);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addra_nxt;
    logic [ADDR_W-1:0] addrb_nxt;
    logic [31:0]       data_q;
    logic [7:0]        rnd_q;
    tag_t              tag_issue;
    tag_t              tag_sr [BRAM_LAT];
    logic [CRED_W-1:0] credits;
    logic [15:0]       lo_hold;
    logic              accept;
    logic              pop;
    logic              push;
    logic              fifo_empty;
    logic              fifo_full_unused;

    assign in_ready = rst && (state != LO) && (credits != '0);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign push     = (tag_sr[BRAM_LAT-1] == TAG_HI);
    assign bram_en  = rst;
    assign bram_rst = ~rst;
    assign out_valid = ~fifo_empty;

    always_comb begin
        state_nxt = state;
        addra_nxt = bram_addra;
        addrb_nxt = bram_addrb;
        tag_issue = TAG_NONE;
        case (state)
            IDLE, HI: begin
                if (state == HI) tag_issue = TAG_HI;
                if (accept) begin
                    // Lane 0/1 addresses come straight from the port so they appear the cycle after accept.
                    state_nxt = LO;
                    addra_nxt = sbox_addr(in_rnd[1:0], in_data[7:0]);
                    addrb_nxt = sbox_addr(in_rnd[3:2], in_data[15:8]);
                end else begin
                    state_nxt = IDLE;
                end
            end
            LO: begin
                tag_issue = TAG_LO;
                state_nxt = HI;
                addra_nxt = sbox_addr(rnd_q[5:4], data_q[23:16]);
                addrb_nxt = sbox_addr(rnd_q[7:6], data_q[31:24]);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bram_addra <= '0;
            bram_addrb <= '0;
            credits    <= CRED_W'(FIFO_DEPTH);
            for (int i = 0; i < BRAM_LAT; i++) tag_sr[i] <= TAG_NONE;
        end else begin
            state      <= state_nxt;
            bram_addra <= addra_nxt;
            bram_addrb <= addrb_nxt;
            tag_sr[0]  <= tag_issue;
            for (int i = 1; i < BRAM_LAT; i++) tag_sr[i] <= tag_sr[i-1];
            case ({accept, pop})
                2'b10:   credits <= credits - CRED_W'(1);
                2'b01:   credits <= credits + CRED_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= in_data;
            rnd_q  <= in_rnd;
        end
        if (tag_sr[BRAM_LAT-1] == TAG_LO) lo_hold <= {bram_dob, bram_doa};
    end

    sbox_out_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .DATA_W    (32)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({bram_dob, bram_doa, lo_hold}),
        .pop      (pop),
        .head     (out_data),
        .full     (fifo_full_unused),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_sbox_quarter_sequencer.sv
// Bench for sbox_quarter_sequencer: behavioural 2-cycle BRAM with a stand-in x49 table,
// a transaction-level reference model checked every cycle, and directed literal pins.
module tb_sbox_quarter_sequencer;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_rnd = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [9:0]  bram_addra;
    logic [9:0]  bram_addrb;
    logic        bram_en;
    logic        bram_rst;
    logic [7:0]  bram_doa;
    logic [7:0]  bram_dob;
    logic        out_valid;
    logic [31:0] out_data;

    int checks = 0;
    int failures = 0;
    int seq = 0;

    always #5 clk = ~clk;

    sbox_quarter_sequencer #(.BRAM_LAT(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rnd    (in_rnd),
        .bram_addra(bram_addra),
        .bram_addrb(bram_addrb),
        .bram_en   (bram_en),
        .bram_rst  (bram_rst),
        .bram_doa  (bram_doa),
        .bram_dob  (bram_dob),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [7:0] tbl(input logic [9:0] a);
        return a[7:0] ^ {4{a[9:8]}} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] d, input logic [7:0] r);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) res[8*k +: 8] = tbl({r[2*k +: 2], d[8*k +: 8]});
        return res;
    endfunction

    // Dual-port BRAM: address register then output register.
    logic [7:0] mem_a;
    logic [7:0] mem_b;
    always @(posedge clk) begin
        if (bram_rst) begin
            mem_a    <= '0;
            mem_b    <= '0;
            bram_doa <= '0;
            bram_dob <= '0;
        end else if (bram_en) begin
            mem_a    <= tbl(bram_addra);
            mem_b    <= tbl(bram_addrb);
            bram_doa <= mem_a;
            bram_dob <= mem_b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] w;
        int          rdy;
    } ent_t;

    // Reference model: accepted words become visible 5 cycles later, in order.
    initial begin
        ent_t        q[$];
        int          cyc;
        int          outstanding;
        int          last_acc;
        logic [31:0] last_d;
        logic [7:0]  last_r;
        logic [9:0]  ea;
        logic [9:0]  eb;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        cyc = 0; outstanding = 0; last_acc = -100;
        last_d = '0; last_r = '0; ea = '0; eb = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("rst_in_ready", in_ready, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_addra", bram_addra, 0);
                chk("rst_addrb", bram_addrb, 0);
                chk("rst_bram_en", bram_en, 0);
                chk("rst_bram_rst", bram_rst, 1);
                q.delete();
                outstanding = 0;
                last_acc = -100;
                ea = '0;
                eb = '0;
            end else begin
                exp_ready = (cyc != last_acc + 1) && (outstanding < DEPTH);
                if (cyc == last_acc + 1) begin
                    ea = {last_r[1:0], last_d[7:0]};
                    eb = {last_r[3:2], last_d[15:8]};
                end else if (cyc == last_acc + 2) begin
                    ea = {last_r[5:4], last_d[23:16]};
                    eb = {last_r[7:6], last_d[31:24]};
                end
                exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
                exp_data  = exp_valid ? q[0].w : 32'h0;
                chk("in_ready", in_ready, exp_ready);
                chk("out_valid", out_valid, exp_valid);
                chk("out_data", out_data, exp_data);
                chk("addra", bram_addra, ea);
                chk("addrb", bram_addrb, eb);
                chk("bram_en", bram_en, 1);
                chk("bram_rst", bram_rst, 0);
                if (exp_valid && out_ready) begin
                    void'(q.pop_front());
                    outstanding--;
                end
                if (in_valid && exp_ready) begin
                    q.push_back('{w: sub_word(in_data, in_rnd), rdy: cyc + 5});
                    outstanding++;
                    last_acc = cyc;
                    last_d = in_data;
                    last_r = in_rnd;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [7:0] r);
        int n;
        n = 0;
        in_data = d;
        in_rnd = r;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_wait: in_ready never rose within %0d cycles", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_and_pin(input logic [31:0] d, input logic [7:0] r,
                                input logic [9:0] a0, input logic [9:0] b0,
                                input logic [9:0] a1, input logic [9:0] b1,
                                input logic [31:0] w);
        send(d, r);
        chk("pin_addra_lo", bram_addra, a0);
        chk("pin_addrb_lo", bram_addrb, b0);
        @(posedge clk); #1;
        chk("pin_addra_hi", bram_addra, a1);
        chk("pin_addrb_hi", bram_addrb, b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pin_out_valid", out_valid, 1);
        chk("pin_out_data", out_data, w);
    endtask

    task automatic load_seq();
        in_data = 32'h1F2E3D4C + 32'(seq) * 32'h01234567;
        in_rnd  = 8'(seq * 37 + 5);
    endtask

    task automatic stream(input int nw, input int maxc, output int acc);
        logic rdy;
        acc = 0;
        load_seq();
        in_valid = 1'b1;
        for (int c = 0; c < maxc && acc < nw; c++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc++;
                seq++;
                load_seq();
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rst_in_ready", in_ready, 0);
        chk("hold_rst_out_data", out_data, 0);
        rst = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);

        send_and_pin(32'h0000_0000, 8'h00, 10'h000, 10'h000, 10'h000, 10'h000, 32'h6363_6363);
        send_and_pin(32'h3322_1100, 8'hE4, 10'h000, 10'h111, 10'h222, 10'h333, 32'hAFEB_2763);
        repeat (4) @(posedge clk);
        #1;

        stream(8, 200, n);
        chk("stream8_accepts", n, 8);
        repeat (12) @(posedge clk);
        #1;

        out_ready = 1'b0;
        stream(8, 10, n);
        chk("stall_accepts", n, 2);
        load_seq();
        in_valid = 1'b1;
        out_ready = 1'b1;
        chk("pop_cycle_in_ready", in_ready, 0);
        chk("pop_cycle_out_valid", out_valid, 1);
        stream(4, 100, n);
        chk("resume_accepts", n, 4);
        repeat (15) @(posedge clk);
        #1;

        send(32'h0BAD_F00D, 8'h5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_idle_valid", out_valid, 0);
        send_and_pin(32'hFFEE_DDCC, 8'h1B, 10'h3CC, 10'h2DD, 10'h1EE, 10'h0FF, 32'h9CD8_1450);

        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
